tilt_direction_decoder: RTL and testbench
=========================================

// Module: tilt_direction_decoder
// PURPOSE
//  Multi-axis accelerometer tilt classifier: converts per-axis unsigned samples into debounced
//  POS/REST/NEG direction flags with deadband, hysteresis, runtime recentring and change strobes.
//  Sits between the accelerometer SPI reader and the game logic, replacing the hard-coded
//  single-threshold up/down/left/right compare. One tilt_axis instance per axis.
// PARAMETERS
//  NUM_AXES       2              number of independent axes
//  WIDTH          9              sample width, unsigned
//  CENTER_INIT    {9'd80,9'd385} packed NUM_AXES*WIDTH reset centres; axis0 in LSBs
//  DEADBAND       0              |sample-centre| must exceed this to leave REST
//  HYST           0              release margin; must satisfy HYST <= DEADBAND
//  DEBOUNCE       1              consecutive valid samples needed to commit a new state (>=1)
//  REPEAT_DELAY   50_000_000     clocks held before first repeat pulse (TILT_AUTOREPEAT_EN only)
//  REPEAT_PERIOD  10_000_000     clocks between subsequent repeat pulses (TILT_AUTOREPEAT_EN only)
// PORTS
//  clock          in   1               system clock
//  reset          in   1               synchronous, active-high
//  sample_valid   in   1               sample_data valid this cycle (all axes together)
//  sample_data    in   NUM_AXES*WIDTH  packed unsigned samples, axis0 in LSBs
//  cal_capture    in   1               with sample_valid: current samples become new centres
//  dir_pos        out  NUM_AXES        axis committed POS (sample > centre)
//  dir_neg        out  NUM_AXES        axis committed NEG
//  dir_rest       out  NUM_AXES        axis committed REST
//  change_pulse   out  NUM_AXES        1-cycle strobe when the axis's committed state changes
//  repeat_pulse   out  NUM_AXES        1-cycle auto-repeat strobe while held POS/NEG
// BEHAVIOUR
//  - Reset: state=REST per axis, dir_rest=all 1, dir_pos/dir_neg/change_pulse/repeat_pulse=0,
//    centres=CENTER_INIT, debounce and repeat counters=0. Reset wins over every other input.
//  - Per axis diff = {1'b0,sample}-{1'b0,centre}, signed WIDTH+1 bits; no overflow possible.
//  - Candidate: from REST/NEG -> POS if diff > DEADBAND; from POS stays POS while diff > DEADBAND-HYST.
//    Symmetric for NEG (diff < -DEADBAND; hold while diff < -(DEADBAND-HYST)); otherwise REST.
//    Direct POS<->NEG candidate is legal.
//  - Debounce, evaluated only on sample_valid: candidate==state -> cnt=0; candidate!=state and
//    equal to previous candidate -> cnt+1; differs from previous candidate -> cnt=1. Commit when
//    cnt reaches DEBOUNCE (DEBOUNCE=1 commits on first differing sample); cnt cleared on commit.
//  - No sample_valid: state, counters, candidate frozen.
//  - Latency: dir_* and change_pulse are registered; they reflect a commit the cycle after the
//    clock edge at which the committing sample_valid was sampled. change_pulse high exactly 1 cycle.
//  - dir_pos/dir_neg/dir_rest are one-hot per axis at all times.
//  - cal_capture && sample_valid: centres <= sample_data; every axis forced to REST, cnt=0,
//    change_pulse for axes that were not REST; classification of that sample is discarded.
//    cal_capture without sample_valid is ignored.
//  - Defaults (DEADBAND=0,HYST=0,DEBOUNCE=1) reproduce the legacy strict >, <, == compare.
// CONFIGURATION
//  TILT_AUTOREPEAT_EN defined: per-axis clock counter runs while state is POS or NEG; repeat_pulse
//    fires 1 cycle at REPEAT_DELAY clocks after commit, then every REPEAT_PERIOD; counter cleared on
//    any state change, cal_capture or reset; saturating, no wrap.
//  Undefined: repeat_pulse tied 0, no repeat counters synthesised; port still present.
// STRUCTURE
//  tilt_pkg: state encoding TILT_REST=2'd0/TILT_POS=2'd1/TILT_NEG=2'd2, $clog2 width helpers.
//  Sub-module tilt_axis: one axis (centre reg, classifier, debounce, optional repeat), generated
//  NUM_AXES times; top only slices buses and fans out cal_capture.
// TESTING
//  1 Defaults, axis0 samples 384,385,386 -> dir_neg, dir_rest, dir_pos in turn, change_pulse each step.
//  2 DEADBAND=8,HYST=4,axis0 centre 385: 394 -> POS; 390 -> stays POS; 389 -> REST; 376 -> NEG.
//  3 DEBOUNCE=3: 400,400,385,400,400,400 -> commit POS only on 6th valid, single change_pulse.
//  4 State POS, cal_capture+valid with sample 400 -> centre=400, REST, change_pulse; next 401 -> POS.
//  5 Reset asserted mid-debounce (cnt=2) -> all axes REST, cnt 0, outputs at reset values next cycle.
//  6 TILT_AUTOREPEAT_EN, DELAY=10,PERIOD=4, hold POS -> repeat_pulse at +10,+14,+18; REST stops it.

Source files
------------

// File: rtl/tilt_direction_decoder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : tilt_direction_decoder_pkg                                       |
// | Purpose : Shared tilt-state encoding and counter width helper for the      |
// |           multi-axis tilt direction decoder.                               |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package tilt_direction_decoder_pkg;

  typedef enum logic [1:0] {
    TILT_REST = 2'd0,
    TILT_POS  = 2'd1,
    TILT_NEG  = 2'd2
  } tilt_state_e;

  // Bits needed to hold the values 0..n, never less than one bit.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/tilt_direction_decoder_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : tilt_direction_decoder_if                                      |
// | Purpose   : Sample input bus and per-axis direction outputs of the tilt    |
// |             decoder. The master drives samples, the slave is the decoder.  |
// | Rev       : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
interface tilt_direction_decoder_if #(
  parameter int NUM_AXES = 2,
  parameter int WIDTH    = 9
);
  logic                      sample_valid;
  logic [NUM_AXES*WIDTH-1:0] sample_data;
  logic                      cal_capture;
  logic [NUM_AXES-1:0]       dir_pos;
  logic [NUM_AXES-1:0]       dir_neg;
  logic [NUM_AXES-1:0]       dir_rest;
  logic [NUM_AXES-1:0]       change_pulse;
  logic [NUM_AXES-1:0]       repeat_pulse;

  modport master (
    output sample_valid, sample_data, cal_capture,
    input  dir_pos, dir_neg, dir_rest, change_pulse, repeat_pulse
  );

  modport slave (
    input  sample_valid, sample_data, cal_capture,
    output dir_pos, dir_neg, dir_rest, change_pulse, repeat_pulse
  );
endinterface
`default_nettype wire

// File: rtl/tilt_direction_decoder_axis.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tilt_direction_decoder_axis                                      |
// | Purpose : One tilt axis: runtime centre register, deadband/hysteresis      |
// |           classifier, debounce and optional auto-repeat.                   |
// | Config  : TILT_AUTOREPEAT_EN enables the repeat_pulse counter.             |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tilt_direction_decoder_axis
  import tilt_direction_decoder_pkg::*;
#(
  parameter int               WIDTH         = 9,
  parameter logic [WIDTH-1:0] CENTER_INIT   = '0,
  parameter int               DEADBAND      = 0,
  parameter int               HYST          = 0,
  parameter int               DEBOUNCE      = 1,
  parameter int               REPEAT_DELAY  = 50_000_000,
  parameter int               REPEAT_PERIOD = 10_000_000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sample_valid,
  input  logic             cal_capture,
  input  logic [WIDTH-1:0] sample,
  output logic             dir_pos,
  output logic             dir_neg,
  output logic             dir_rest,
  output logic             change_pulse,
  output logic             repeat_pulse
);

  localparam int              CW      = cnt_w(DEBOUNCE);
  localparam logic [CW-1:0]   C_DEB   = CW'(DEBOUNCE);
  localparam int signed       C_ENTER = DEADBAND;
  localparam int signed       C_HOLD  = DEADBAND - HYST;

  logic [WIDTH-1:0]   centre_q, centre_d;
  tilt_state_e        state_q, state_d;
  tilt_state_e        cand_q, cand_d;
  tilt_state_e        cand;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               change_q, change_d;
  logic signed [WIDTH:0] diff;
  logic signed [31:0]    diff_w;

  // Zero-extended operands make the WIDTH+1 bit difference exact.
  assign diff   = $signed({1'b0, sample}) - $signed({1'b0, centre_q});
  assign diff_w = 32'(diff);

  // Classify the sample: entry needs DEADBAND, holding only DEADBAND-HYST.
  always_comb begin
    cand = TILT_REST;
    unique case (state_q)
      TILT_POS: begin
        if (diff_w > C_HOLD)          cand = TILT_POS;
        else if (diff_w < -C_ENTER)   cand = TILT_NEG;
      end
      TILT_NEG: begin
        if (diff_w < -C_HOLD)         cand = TILT_NEG;
        else if (diff_w > C_ENTER)    cand = TILT_POS;
      end
      default: begin
        if (diff_w > C_ENTER)         cand = TILT_POS;
        else if (diff_w < -C_ENTER)   cand = TILT_NEG;
      end
    endcase
  end

  // Debounce the candidate and handle recentring; frozen without sample_valid.
  always_comb begin
    centre_d = centre_q;
    state_d  = state_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    change_d = 1'b0;
    if (sample_valid && cal_capture) begin
      centre_d = sample;
      state_d  = TILT_REST;
      cand_d   = TILT_REST;
      cnt_d    = '0;
      change_d = (state_q != TILT_REST);
    end else if (sample_valid) begin
      cand_d = cand;
      if (cand == state_q)     cnt_d = '0;
      else if (cand == cand_q) cnt_d = cnt_q + CW'(1);
      else                     cnt_d = CW'(1);
      if ((cand != state_q) && (cnt_d >= C_DEB)) begin
        state_d  = cand;
        cnt_d    = '0;
        change_d = 1'b1;
      end
    end
  end

  // Axis state registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      centre_q <= CENTER_INIT;
      state_q  <= TILT_REST;
      cand_q   <= TILT_REST;
      cnt_q    <= '0;
      change_q <= 1'b0;
    end else begin
      centre_q <= centre_d;
      state_q  <= state_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      change_q <= change_d;
    end
  end

  assign dir_pos      = (state_q == TILT_POS);
  assign dir_neg      = (state_q == TILT_NEG);
  assign dir_rest     = (state_q == TILT_REST);
  assign change_pulse = change_q;

`ifdef TILT_AUTOREPEAT_EN
  localparam int            RW        = cnt_w(REPEAT_DELAY);
  localparam logic [RW-1:0] C_RDELAY  = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] C_RRELOAD = RW'(REPEAT_DELAY - REPEAT_PERIOD);

  logic [RW-1:0] rpt_cnt_q, rpt_cnt_d;
  logic          repeat_q, repeat_d;

  // Count held clocks; on reaching the delay, pulse and step back one period
  // so later pulses follow every REPEAT_PERIOD without the counter wrapping.
  always_comb begin
    rpt_cnt_d = rpt_cnt_q;
    repeat_d  = 1'b0;
    if ((state_d != state_q) || (sample_valid && cal_capture) ||
        (state_q == TILT_REST)) begin
      rpt_cnt_d = '0;
    end else if (rpt_cnt_q + RW'(1) == C_RDELAY) begin
      repeat_d  = 1'b1;
      rpt_cnt_d = C_RRELOAD;
    end else begin
      rpt_cnt_d = rpt_cnt_q + RW'(1);
    end
  end

  // Auto-repeat registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      rpt_cnt_q <= '0;
      repeat_q  <= 1'b0;
    end else begin
      rpt_cnt_q <= rpt_cnt_d;
      repeat_q  <= repeat_d;
    end
  end

  assign repeat_pulse = repeat_q;
`else
  assign repeat_pulse = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/tilt_direction_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tilt_direction_decoder                                           |
// | Purpose : Multi-axis accelerometer tilt classifier producing debounced     |
// |           POS/REST/NEG flags, change strobes and optional repeat strobes.  |
// | Config  : TILT_AUTOREPEAT_EN enables per-axis auto-repeat counters.        |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tilt_direction_decoder
  import tilt_direction_decoder_pkg::*;
#(
  parameter int                        NUM_AXES      = 2,
  parameter int                        WIDTH         = 9,
  parameter logic [NUM_AXES*WIDTH-1:0] CENTER_INIT   = {9'd80, 9'd385},
  parameter int                        DEADBAND      = 0,
  parameter int                        HYST          = 0,
  parameter int                        DEBOUNCE      = 1,
  parameter int                        REPEAT_DELAY  = 50_000_000,
  parameter int                        REPEAT_PERIOD = 10_000_000
) (
  input  logic                     clock,
  input  logic                     reset,
  tilt_direction_decoder_if.slave  bus
);

  logic [NUM_AXES-1:0] pos_vec;
  logic [NUM_AXES-1:0] neg_vec;
  logic [NUM_AXES-1:0] rest_vec;
  logic [NUM_AXES-1:0] change_vec;
  logic [NUM_AXES-1:0] repeat_vec;

  // One independent axis per slice; cal_capture and sample_valid fan out to all.
  for (genvar i = 0; i < NUM_AXES; i++) begin : g_axis
    tilt_direction_decoder_axis #(
      .WIDTH         (WIDTH),
      .CENTER_INIT   (CENTER_INIT[i*WIDTH +: WIDTH]),
      .DEADBAND      (DEADBAND),
      .HYST          (HYST),
      .DEBOUNCE      (DEBOUNCE),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_axis (
      .clock        (clock),
      .reset        (reset),
      .sample_valid (bus.sample_valid),
      .cal_capture  (bus.cal_capture),
      .sample       (bus.sample_data[i*WIDTH +: WIDTH]),
      .dir_pos      (pos_vec[i]),
      .dir_neg      (neg_vec[i]),
      .dir_rest     (rest_vec[i]),
      .change_pulse (change_vec[i]),
      .repeat_pulse (repeat_vec[i])
    );
  end

  assign bus.dir_pos      = pos_vec;
  assign bus.dir_neg      = neg_vec;
  assign bus.dir_rest     = rest_vec;
  assign bus.change_pulse = change_vec;
  assign bus.repeat_pulse = repeat_vec;

endmodule
`default_nettype wire

// File: tb/tb_tilt_direction_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_tilt_direction_decoder                                        |
// | Purpose : Directed scoreboard bench for tilt_direction_decoder using three |
// |           instances (defaults, deadband/hysteresis, debounce of 3).        |
// | Config  : TILT_AUTOREPEAT_EN selects the expected repeat_pulse pattern.    |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_tilt_direction_decoder;

`ifdef TILT_AUTOREPEAT_EN
  localparam bit AUTOREP = 1'b1;
`else
  localparam bit AUTOREP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  tilt_direction_decoder_if #(.NUM_AXES(2), .WIDTH(9)) if0 ();
  tilt_direction_decoder_if #(.NUM_AXES(2), .WIDTH(9)) if1 ();
  tilt_direction_decoder_if #(.NUM_AXES(2), .WIDTH(9)) if2 ();

  tilt_direction_decoder #(.REPEAT_DELAY(10), .REPEAT_PERIOD(4)) u0 (
    .clock(clk), .reset(rst), .bus(if0.slave));
  tilt_direction_decoder #(.DEADBAND(8), .HYST(4)) u1 (
    .clock(clk), .reset(rst), .bus(if1.slave));
  tilt_direction_decoder #(.DEBOUNCE(3)) u2 (
    .clock(clk), .reset(rst), .bus(if2.slave));

  typedef struct {
    string      tag;
    int         d;
    logic [9:0] exp;
  } sb_t;
  sb_t sb[$];

  // {repeat, change, rest, neg, pos}, two axes each
  function automatic logic [9:0] obs(input int d);
    case (d)
      0:       return {if0.repeat_pulse, if0.change_pulse, if0.dir_rest, if0.dir_neg, if0.dir_pos};
      1:       return {if1.repeat_pulse, if1.change_pulse, if1.dir_rest, if1.dir_neg, if1.dir_pos};
      default: return {if2.repeat_pulse, if2.change_pulse, if2.dir_rest, if2.dir_neg, if2.dir_pos};
    endcase
  endfunction

  task automatic step(input int d, input bit v, input bit cal, input int s0, input int s1,
                      input string tag, input logic [1:0] pos, input logic [1:0] neg,
                      input logic [1:0] rest, input logic [1:0] chg, input logic [1:0] rpt);
    sb_t        e;
    logic [9:0] got;
    case (d)
      0: begin if0.sample_valid = v; if0.cal_capture = cal; if0.sample_data = {9'(s1), 9'(s0)}; end
      1: begin if1.sample_valid = v; if1.cal_capture = cal; if1.sample_data = {9'(s1), 9'(s0)}; end
      default: begin if2.sample_valid = v; if2.cal_capture = cal; if2.sample_data = {9'(s1), 9'(s0)}; end
    endcase
    sb.push_back('{tag, d, {rpt, chg, rest, neg, pos}});
    @(posedge clk);
    #1;
    if0.sample_valid = 1'b0; if0.cal_capture = 1'b0;
    if1.sample_valid = 1'b0; if1.cal_capture = 1'b0;
    if2.sample_valid = 1'b0; if2.cal_capture = 1'b0;
    e   = sb.pop_front();
    got = obs(e.d);
    checks++;
    assert (got === e.exp)
    else begin
      errors++;
      $error("FAIL %s: observed %b expected %b (rpt,chg,rest,neg,pos)", e.tag, got, e.exp);
    end
  endtask

  initial begin
    if0.sample_valid = 1'b0; if0.cal_capture = 1'b0; if0.sample_data = '0;
    if1.sample_valid = 1'b0; if1.cal_capture = 1'b0; if1.sample_data = '0;
    if2.sample_valid = 1'b0; if2.cal_capture = 1'b0; if2.sample_data = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state of every instance
    step(0, 0, 0, 385, 80, "reset0", 2'b00, 2'b00, 2'b11, 2'b00, 2'b00);
    step(1, 0, 0, 385, 80, "reset1", 2'b00, 2'b00, 2'b11, 2'b00, 2'b00);
    step(2, 0, 0, 385, 80, "reset2", 2'b00, 2'b00, 2'b11, 2'b00, 2'b00);

    // Legacy strict compare around centre 385 (axis0) and 80 (axis1)
    step(0, 1, 0, 384, 80, "neg384",     2'b00, 2'b01, 2'b10, 2'b01, 2'b00);
    step(0, 0, 0, 384, 80, "hold_idle",  2'b00, 2'b01, 2'b10, 2'b00, 2'b00);
    step(0, 1, 0, 385, 80, "rest385",    2'b00, 2'b00, 2'b11, 2'b01, 2'b00);
    step(0, 1, 0, 386, 80, "pos386",     2'b01, 2'b00, 2'b10, 2'b01, 2'b00);
    step(0, 1, 0, 386, 80, "pos_again",  2'b01, 2'b00, 2'b10, 2'b00, 2'b00);
    step(0, 1, 0, 386, 81, "ax1_pos",    2'b11, 2'b00, 2'b00, 2'b10, 2'b00);
    step(0, 1, 0, 386, 79, "ax1_pos2neg",2'b01, 2'b10, 2'b00, 2'b10, 2'b00);

    // Recentring
    step(0, 0, 1, 400, 79, "cal_no_valid", 2'b01, 2'b10, 2'b00, 2'b00, 2'b00);
    step(0, 1, 1, 400, 79, "cal",          2'b00, 2'b00, 2'b11, 2'b11, 2'b00);
    step(0, 1, 0, 400, 79, "post_cal400",  2'b00, 2'b00, 2'b11, 2'b00, 2'b00);
    step(0, 1, 0, 401, 79, "pos401",       2'b01, 2'b00, 2'b10, 2'b01, 2'b00);

    // Held POS: repeat at +10, +14, +18 clocks when auto-repeat is built in
    for (int k = 1; k <= 20; k++) begin
      step(0, 0, 0, 401, 79, $sformatf("repeat_k%0d", k), 2'b01, 2'b00, 2'b10, 2'b00,
           (AUTOREP && (k == 10 || k == 14 || k == 18)) ? 2'b01 : 2'b00);
    end
    step(0, 1, 0, 400, 79, "rest400", 2'b00, 2'b00, 2'b11, 2'b01, 2'b00);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 400, 79, "no_repeat", 2'b00, 2'b00, 2'b11, 2'b00, 2'b00);
    end

    // Deadband 8, hysteresis 4, centre 385
    step(1, 1, 0, 393, 80, "db393",   2'b00, 2'b00, 2'b11, 2'b00, 2'b00);
    step(1, 1, 0, 394, 80, "db394",   2'b01, 2'b00, 2'b10, 2'b01, 2'b00);
    step(1, 1, 0, 390, 80, "hyst390", 2'b01, 2'b00, 2'b10, 2'b00, 2'b00);
    step(1, 1, 0, 389, 80, "hyst389", 2'b00, 2'b00, 2'b11, 2'b01, 2'b00);
    step(1, 1, 0, 377, 80, "db377",   2'b00, 2'b00, 2'b11, 2'b00, 2'b00);
    step(1, 1, 0, 376, 80, "db376",   2'b00, 2'b01, 2'b10, 2'b01, 2'b00);
    step(1, 1, 0, 380, 80, "hyst380", 2'b00, 2'b01, 2'b10, 2'b00, 2'b00);
    step(1, 1, 0, 381, 80, "hyst381", 2'b00, 2'b00, 2'b11, 2'b01, 2'b00);

    // Debounce of 3 with an interrupting REST sample
    step(2, 1, 0, 400, 80, "deb_1", 2'b00, 2'b00, 2'b11, 2'b00, 2'b00);
    step(2, 1, 0, 400, 80, "deb_2", 2'b00, 2'b00, 2'b11, 2'b00, 2'b00);
    step(2, 1, 0, 385, 80, "deb_3", 2'b00, 2'b00, 2'b11, 2'b00, 2'b00);
    step(2, 1, 0, 400, 80, "deb_4", 2'b00, 2'b00, 2'b11, 2'b00, 2'b00);
    step(2, 1, 0, 400, 80, "deb_5", 2'b00, 2'b00, 2'b11, 2'b00, 2'b00);
    step(2, 1, 0, 400, 80, "deb_6", 2'b01, 2'b00, 2'b10, 2'b01, 2'b00);
    step(2, 0, 0, 400, 80, "deb_idle", 2'b01, 2'b00, 2'b10, 2'b00, 2'b00);

    // Reset in the middle of a debounce run
    step(2, 1, 0, 385, 80, "mid_1", 2'b01, 2'b00, 2'b10, 2'b00, 2'b00);
    step(2, 1, 0, 385, 80, "mid_2", 2'b01, 2'b00, 2'b10, 2'b00, 2'b00);
    rst = 1'b1;
    step(2, 1, 0, 400, 80, "reset_wins", 2'b00, 2'b00, 2'b11, 2'b00, 2'b00);
    rst = 1'b0;
    step(0, 0, 0, 400, 80, "reset_dut0", 2'b00, 2'b00, 2'b11, 2'b00, 2'b00);
    step(2, 1, 0, 400, 80, "post_rst_1", 2'b00, 2'b00, 2'b11, 2'b00, 2'b00);
    step(2, 1, 0, 400, 80, "post_rst_2", 2'b00, 2'b00, 2'b11, 2'b00, 2'b00);
    step(2, 1, 0, 400, 80, "post_rst_3", 2'b01, 2'b00, 2'b10, 2'b01, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
